// File: rtl/assert_pkg.sv
// rtl/assert_pkg.sv - shared types and helpers for the assertion message gate and pli stop logic
package assert_pkg;

    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        HOLD     = 2'd1,
        ARMED    = 2'd2,
        HALT     = 2'd3
    } gate_state_e;

    // Widest source vector / counter the helpers handle.
    localparam int MAX_W = 32;

    function automatic logic [5:0] popcount(input logic [MAX_W-1:0] vec);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {5'd0, vec[i]};
        end
        return n;
    endfunction

    // Add with one guard bit, clamping to all-ones of a `width`-bit counter.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] cnt,
                                                 input logic [MAX_W-1:0] inc,
                                                 input int unsigned      width);
        logic [MAX_W:0] sum;
        logic [MAX_W:0] max_val;
        sum     = {1'b0, cnt} + {1'b0, inc};
        max_val = (33'd1 << width) - 33'd1;
        if (sum > max_val) begin
            return max_val[MAX_W-1:0];
        end
        return sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating counter advanced by the popcount of a pulse vector
// Ports:
//   clk, reset_l      clock and synchronous active-low reset
//   inc_vec [NSRC]    pulses; each set bit adds one
//   en                count enable (pulses ignored when low)
//   clr               zero the count next cycle; wins over en
//   count  [CNT_W]    registered count
//   count_next [CNT_W] value count takes at the next edge
module sat_counter
    import assert_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NSRC  = 4
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [NSRC-1:0]  inc_vec,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    logic [MAX_W-1:0] vec_ext;
    logic [MAX_W-1:0] cnt_ext;
    logic [MAX_W-1:0] inc_ext;
    logic [CNT_W-1:0] sum;

    always_comb begin
        vec_ext              = '0;
        vec_ext[NSRC-1:0]    = inc_vec;
        cnt_ext              = '0;
        cnt_ext[CNT_W-1:0]   = count;
        inc_ext              = '0;
        inc_ext[5:0]         = popcount(vec_ext);
        sum                  = CNT_W'(sat_add(cnt_ext, inc_ext, CNT_W));
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = sum;
        end else begin
            count_next = count;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/assert_msg_gate.sv
// rtl/assert_msg_gate.sv - qualifies assertion pulses against design reset and counts them
// Ports:
//   clk, reset_l        clock and synchronous active-low block reset
//   dut_reset_l         design reset level (low = design in reset)
//   err_vld, warn_vld   per-source one-cycle error / warning pulses
//   clear               zero counts and sticky mask, leave HALT
//   message_on          checking enabled (ARMED or HALT)
//   errors, warnings    saturating qualified counts
//   err_src             sticky mask of sources that logged an error
//   stop_req            stop request while in HALT
module assert_msg_gate
    import assert_pkg::*;
#(
    parameter int NSRC       = 4,
    parameter int HOLDOFF    = 16,
    parameter int CNT_W      = 16,
    parameter int WARN_LIMIT = 0
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             dut_reset_l,
    input  logic [NSRC-1:0]  err_vld,
    input  logic [NSRC-1:0]  warn_vld,
    input  logic             clear,
    output logic             message_on,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] warnings,
    output logic [NSRC-1:0]  err_src,
    output logic             stop_req
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

    gate_state_e      state, state_next;
    logic [15:0]      hold_cnt, hold_cnt_next;
    logic             counting;
    logic [CNT_W-1:0] errors_next, warnings_next;
    logic [31:0]      warn_ext;
    logic             warn_hit;

    assign counting = (state == ARMED) || (state == HALT);

    sat_counter #(.CNT_W(CNT_W), .NSRC(NSRC)) u_err_cnt (
        .clk        (clk),
        .reset_l    (reset_l),
        .inc_vec    (err_vld),
        .en         (counting),
        .clr        (clear),
        .count      (errors),
        .count_next (errors_next)
    );

    sat_counter #(.CNT_W(CNT_W), .NSRC(NSRC)) u_warn_cnt (
        .clk        (clk),
        .reset_l    (reset_l),
        .inc_vec    (warn_vld),
        .en         (counting),
        .clr        (clear),
        .count      (warnings),
        .count_next (warnings_next)
    );

    // Halt decisions look at the post-update counts so stop_req rises on
    // the same edge that makes the count cross the threshold.
    always_comb begin
        warn_ext              = '0;
        warn_ext[CNT_W-1:0]   = warnings_next;
        warn_hit              = (WARN_LIMIT != 0) && (warn_ext >= 32'(WARN_LIMIT));
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            WAIT_RST: begin
                hold_cnt_next = '0;
                if (dut_reset_l) begin
                    state_next = (HOLDOFF == 0) ? ARMED : HOLD;
                end
            end
            HOLD: begin
                if (!dut_reset_l) begin
                    state_next    = WAIT_RST;
                    hold_cnt_next = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next    = ARMED;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + 16'd1;
                end
            end
            ARMED: begin
                if (!dut_reset_l) begin
                    state_next = WAIT_RST;
                end else if ((errors_next != '0) || warn_hit) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (!dut_reset_l) begin
                    state_next = WAIT_RST;
                end else if (clear) begin
                    state_next = ARMED;
                end
            end
            default: begin
                state_next    = WAIT_RST;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state      <= WAIT_RST;
            hold_cnt   <= '0;
            err_src    <= '0;
            message_on <= 1'b0;
            stop_req   <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            message_on <= (state_next == ARMED) || (state_next == HALT);
            stop_req   <= (state_next == HALT);
            if (clear) begin
                err_src <= '0;
            end else if (counting) begin
                err_src <= err_src | err_vld;
            end
        end
    end

endmodule

// File: tb/tb_assert_msg_gate.sv
// tb/tb_assert_msg_gate.sv - self-checking bench for assert_msg_gate
module tb_assert_msg_gate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_l, dut_reset_l, clear;
    logic [3:0] err_vld, warn_vld;

    // Instance A: HOLDOFF=16, 4-bit counters, warning stop disabled
    logic        a_msg, a_stop;
    logic [3:0]  a_err, a_warn, a_src;
    // Instance B: HOLDOFF=0, 16-bit counters, stop at 5 warnings
    logic        b_msg, b_stop;
    logic [15:0] b_err, b_warn;
    logic [3:0]  b_src;

    assert_msg_gate #(.NSRC(4), .HOLDOFF(16), .CNT_W(4), .WARN_LIMIT(0)) u_a (
        .clk(clk), .reset_l(reset_l), .dut_reset_l(dut_reset_l),
        .err_vld(err_vld), .warn_vld(warn_vld), .clear(clear),
        .message_on(a_msg), .errors(a_err), .warnings(a_warn),
        .err_src(a_src), .stop_req(a_stop)
    );

    assert_msg_gate #(.NSRC(4), .HOLDOFF(0), .CNT_W(16), .WARN_LIMIT(5)) u_b (
        .clk(clk), .reset_l(reset_l), .dut_reset_l(dut_reset_l),
        .err_vld(err_vld), .warn_vld(warn_vld), .clear(clear),
        .message_on(b_msg), .errors(b_err), .warnings(b_warn),
        .err_src(b_src), .stop_req(b_stop)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         run;   // consecutive cycles dut_reset_l sampled high
        bit         msg;
        bit         stop;
        int         err;
        int         warn;
        logic [3:0] src;
    } model_t;

    model_t ma, mb;

    function automatic model_t step(input model_t m, input logic rl, input logic dr,
                                    input logic [3:0] e, input logic [3:0] w, input logic c,
                                    input int holdoff, input int cw, input int wl);
        model_t n;
        int     maxv;
        maxv = (1 << cw) - 1;
        if (!rl) begin
            n.run = 0; n.msg = 0; n.stop = 0; n.err = 0; n.warn = 0; n.src = '0;
            return n;
        end
        n     = m;
        n.run = dr ? ((m.run > holdoff) ? m.run : m.run + 1) : 0;
        n.msg = (n.run > holdoff);
        if (c) begin
            n.err = 0; n.warn = 0; n.src = '0;
        end else if (m.msg) begin
            n.err  = m.err + $countones(e);
            n.warn = m.warn + $countones(w);
            if (n.err > maxv)  n.err  = maxv;
            if (n.warn > maxv) n.warn = maxv;
            n.src = m.src | e;
        end
        n.stop = m.msg && dr && ((n.err != 0) || ((wl != 0) && (n.warn >= wl)));
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic rl, input logic dr, input logic [3:0] e,
                         input logic [3:0] w, input logic c);
        reset_l = rl; dut_reset_l = dr; err_vld = e; warn_vld = w; clear = c;
        @(posedge clk);
        ma = step(ma, rl, dr, e, w, c, 16, 4, 0);
        mb = step(mb, rl, dr, e, w, c, 0, 16, 5);
        #1;
        chk("a_msg",  a_msg,  ma.msg);
        chk("a_err",  a_err,  ma.err);
        chk("a_warn", a_warn, ma.warn);
        chk("a_src",  a_src,  ma.src);
        chk("a_stop", a_stop, ma.stop);
        chk("b_msg",  b_msg,  mb.msg);
        chk("b_err",  b_err,  mb.err);
        chk("b_warn", b_warn, mb.warn);
        chk("b_src",  b_src,  mb.src);
        chk("b_stop", b_stop, mb.stop);
    endtask

    typedef struct {
        logic       rl, dr;
        logic [3:0] e, w;
        logic       c;
        int         x_msg, x_err, x_warn, x_src, x_stop;
    } vec_t;

    function automatic vec_t v(input logic dr, input logic [3:0] e, input logic [3:0] w,
                               input logic c, input int xm, input int xe, input int xw,
                               input int xs, input int xp);
        vec_t t;
        t.rl = 1'b1; t.dr = dr; t.e = e; t.w = w; t.c = c;
        t.x_msg = xm; t.x_err = xe; t.x_warn = xw; t.x_src = xs; t.x_stop = xp;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};

        // Expected values for instance A, starting ARMED with zero counts.
        tbl.push_back(v(1, 4'b1011, 4'b0000, 0, 1, 3,  0,  4'b1011, 1));
        tbl.push_back(v(1, 4'b0000, 4'b0000, 0, 1, 3,  0,  4'b1011, 1));
        tbl.push_back(v(1, 4'b0001, 4'b0000, 1, 1, 0,  0,  4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 1, 0,  4,  4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 1, 0,  8,  4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 1, 0,  12, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 1, 0,  15, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 1, 0,  15, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 1, 0,  15, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0100, 4'b0000, 0, 1, 1,  15, 4'b0100, 1));
        tbl.push_back(v(1, 4'b1111, 4'b0000, 0, 1, 5,  15, 4'b1111, 1));
        tbl.push_back(v(1, 4'b1111, 4'b0000, 0, 1, 9,  15, 4'b1111, 1));
        tbl.push_back(v(1, 4'b1111, 4'b0000, 0, 1, 13, 15, 4'b1111, 1));
        tbl.push_back(v(1, 4'b1111, 4'b0000, 0, 1, 15, 15, 4'b1111, 1));
        tbl.push_back(v(1, 4'b0000, 4'b0000, 1, 1, 0,  0,  4'b0000, 0));
        tbl.push_back(v(0, 4'b0010, 4'b0000, 0, 0, 1,  0,  4'b0010, 0));
        tbl.push_back(v(0, 4'b0001, 4'b0000, 0, 0, 1,  0,  4'b0010, 0));

        // Block reset
        for (int i = 0; i < 3; i++) cycle(0, 0, 4'b0000, 4'b0000, 0);
        chk("rst_msg",  a_msg,  0);
        chk("rst_err",  a_err,  0);
        chk("rst_warn", a_warn, 0);
        chk("rst_src",  a_src,  0);
        chk("rst_stop", a_stop, 0);

        for (int i = 0; i < 6; i++) cycle(1, 0, 4'b0000, 4'b0000, 0);

        // Holdoff interrupted 8 cycles in, then restarted
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 4'b0000, 4'b0000, 0);
            chk("hold1_msg", a_msg, 0);
        end
        cycle(1, 0, 4'b0000, 4'b0000, 0);
        chk("hold_drop_msg", a_msg, 0);
        for (int j = 0; j <= 16; j++) begin
            cycle(1, 1, (j == 10) ? 4'b0001 : 4'b0000, 4'b0000, 0);
            chk("holdoff_msg",  a_msg,  (j == 16) ? 1 : 0);
            chk("holdoff_err",  a_err,  0);
            chk("holdoff_stop", a_stop, 0);
        end

        // Table of armed-state vectors
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rl, tbl[i].dr, tbl[i].e, tbl[i].w, tbl[i].c);
            chk($sformatf("tbl%0d_msg", i),  a_msg,  tbl[i].x_msg);
            chk($sformatf("tbl%0d_err", i),  a_err,  tbl[i].x_err);
            chk($sformatf("tbl%0d_warn", i), a_warn, tbl[i].x_warn);
            chk($sformatf("tbl%0d_src", i),  a_src,  tbl[i].x_src);
            chk($sformatf("tbl%0d_stop", i), a_stop, tbl[i].x_stop);
        end

        // Re-arm with errors=1 retained: halts one cycle after arming
        for (int j = 0; j <= 16; j++) cycle(1, 1, 4'b0000, 4'b0000, 0);
        chk("rearm_msg",  a_msg,  1);
        chk("rearm_stop", a_stop, 0);
        cycle(1, 1, 4'b0000, 4'b0000, 0);
        chk("rehalt_stop", a_stop, 1);

        // Block reset with clear in HALT, pulses ignored during reset
        cycle(0, 1, 4'b1111, 4'b1111, 1);
        chk("rst_halt_msg",  a_msg,  0);
        chk("rst_halt_err",  a_err,  0);
        chk("rst_halt_warn", a_warn, 0);
        chk("rst_halt_src",  a_src,  0);
        chk("rst_halt_stop", a_stop, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 4'b1111, 4'b1111, 0);
            chk("rst_pulse_err", a_err, 0);
            chk("rst_pulse_src", a_src, 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       rl, dr, c;
            logic [3:0] e, w;
            rl = ($urandom_range(199) != 0);
            dr = ($urandom_range(79) != 0);
            e  = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
            w  = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0000;
            c  = ($urandom_range(40) == 0);
            cycle(rl, dr, e, w, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/assert_msg_gate.md
# assert_msg_gate

Upstream stage for the `pli` error-count module used with `vpassert --nostop`. It qualifies raw assertion error/warning pulses from up to NSRC checker sources against design reset, and suppresses them until a post-reset holdoff has elapsed. Qualified pulses are accumulated into saturating `errors`/`warnings` counts. The block drives `message_on` and the counts that the `pli` module consumes, and raises `stop_req` when the first error is counted.

## Interface
- `NSRC`, 4: number of checker sources (1..32).
- `HOLDOFF`, 16: cycles after design reset deasserts before `message_on` rises (0..65535).
- `CNT_W`, 16: width of the `errors` and `warnings` counters.
- `WARN_LIMIT`, 0: warning count at which `stop_req` also asserts; 0 disables this.
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset_l`  in  1  synchronous, active-low block reset.
- `dut_reset_l`  in  1  design reset level, already synchronous to `clk`; low means the design is in reset.
- `err_vld`  in  NSRC  one-cycle error pulses, one bit per source.
- `warn_vld`  in  NSRC  one-cycle warning pulses, one bit per source.
- `clear`  in  1  one-cycle request to zero counts and sticky masks.
- `message_on`  out  1  assertion checking enabled.
- `errors`  out  CNT_W  saturating count of qualified errors.
- `warnings`  out  CNT_W  saturating count of qualified warnings.
- `err_src`  out  NSRC  sticky mask of sources that have logged an error.
- `stop_req`  out  1  level output requesting simulation stop.

## Operation
- FSM states: WAIT_RST, HOLD, ARMED, HALT. Reset state is WAIT_RST.
- WAIT_RST:
  - `dut_reset_l`==1 and HOLDOFF>0 → HOLD with the holdoff counter at 0.
  - `dut_reset_l`==1 and HOLDOFF==0 → ARMED.
- HOLD: the counter increments each cycle.
  - Counter reaches HOLDOFF-1 → ARMED.
  - `dut_reset_l`==0 → WAIT_RST, counter cleared.
- ARMED: `message_on`=1.
  - Error pulses are counted every cycle. The per-cycle increment is popcount(`err_vld`), or popcount(`warn_vld`) for warnings, so simultaneous pulses from several sources all count.
  - Sum is computed CNT_W+1 bits wide. If it exceeds 2^CNT_W-1, the counter holds all-ones (saturates, never wraps).
  - `err_src` |= `err_vld`.
  - Post-update `errors`!=0 → HALT.
  - Post-update `warnings`>=WARN_LIMIT with WARN_LIMIT!=0 → HALT.
  - `dut_reset_l`==0 → WAIT_RST. Counts are retained; pulses in that same cycle are still counted.
- HALT: `stop_req`=1 and `message_on` stays 1. Counting continues, with saturation.
  - `dut_reset_l`==0 → WAIT_RST and `stop_req` drops.
- In WAIT_RST and HOLD, `err_vld`/`warn_vld` are dropped: nothing is counted and `err_src` is unchanged.
- `clear`, in any state:
  - Next cycle: `errors`=0, `warnings`=0, `err_src`=0.
  - HALT → ARMED. Other states are unaffected.
  - `clear` takes priority over pulses in the same cycle; those pulses are lost.
- `reset_l`==0 overrides everything, including `clear`.

## Timing
- Reset values: `message_on`=0, `errors`=0, `warnings`=0, `err_src`=0, `stop_req`=0, state WAIT_RST.
- All outputs are registered. No combinational path runs from any input to any output.
- Holdoff: if `dut_reset_l` is first sampled high at edge k, `message_on` is 1 after edge k+HOLDOFF. With HOLDOFF=0 it is 1 after edge k.
- Count latency: a pulse sampled at edge n appears in `errors`/`warnings` after edge n. `stop_req` rises on the same edge that makes `errors` nonzero.
- `message_on` falls on the edge that samples `dut_reset_l`==0.

## Structure
- Shared package `assert_pkg`:
  - state enum `gate_state_e` {WAIT_RST, HOLD, ARMED, HALT};
  - function `popcount`;
  - function `sat_add(cnt, inc)`.
  The `pli`-side stop logic also uses this package.
- One sub-module, `sat_counter`, parameterised on CNT_W and NSRC. It is instantiated twice, once for errors and once for warnings, with inputs `inc_vec`, `en`, `clr`.

## Test plan
- NSRC=4, HOLDOFF=16: `reset_l`=1, raise `dut_reset_l` at edge 10 and pulse `err_vld`=4'b0001 at edge 20 → `message_on`=1 only after edge 26; `errors` stays 0 and `stop_req` stays 0.
- Armed, `err_vld`=4'b1011 for one cycle → `errors`=3 and `err_src`=4'b1011 on the next cycle, with `stop_req`=1 on that same edge.
- CNT_W=4, WARN_LIMIT=0: 6 cycles of `warn_vld`=4'b1111 → `warnings` goes 4, 8, 12, 15, 15, 15 with no wrap; `stop_req` stays 0.
- HALT with `errors`=3: pulse `clear` together with `err_vld`=4'b0001 → next cycle `errors`=0, `err_src`=0, `stop_req`=0, state ARMED.
- HOLDOFF=16: drop `dut_reset_l` to 0 for 1 cycle during HOLD, 8 cycles in → `message_on` rises 16 cycles after the second rise of `dut_reset_l`, not earlier.
- `reset_l`=0 asserted in HALT together with `clear` → all outputs 0 on the next cycle; pulses arriving during `reset_l`=0 are ignored.
